// File: rtl/cache_defs.sv
// Shared data-cache / victim-cache definitions used by the miss-handling path.
package cache_defs;

    localparam int unsigned DCACHE_LINE_WIDTH = 64;
    localparam int unsigned VICTIM_ADDR_BITS  = 26;
    localparam int unsigned VSWAP_CNT_BITS    = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLookup = 3'd1,
        StEvict  = 3'd2,
        StMemReq = 3'd3,
        StFill   = 3'd4
    } vswap_state_t;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating event counter with synchronous clear.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Clear wins over increment; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/victim_swap_ctrl.sv
// Data-cache miss controller: probes the victim cache, writes the evicted line into it,
// then returns the requested line from the victim cache or from memory.
module victim_swap_ctrl
    import cache_defs::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         miss_req_i,
    input  logic [VICTIM_ADDR_BITS-1:0]  miss_addr_i,
    input  logic                         evict_valid_i,
    input  logic [VICTIM_ADDR_BITS-1:0]  evict_addr_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] evict_data_i,
    output logic                         busy_o,
    output logic                         fill_valid_o,
    output logic [VICTIM_ADDR_BITS-1:0]  fill_addr_o,
    output logic [DCACHE_LINE_WIDTH-1:0] fill_data_o,
    output logic [VICTIM_ADDR_BITS-1:0]  vc_addr_o,
    output logic [DCACHE_LINE_WIDTH-1:0] vc_data_o,
    output logic                         vc_write_o,
    input  logic                         vc_hit_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] vc_data_i,
    output logic                         mem_req_o,
    output logic [VICTIM_ADDR_BITS-1:0]  mem_addr_o,
    input  logic                         mem_ack_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] mem_data_i,
    output logic [VSWAP_CNT_BITS-1:0]    hit_cnt_o,
    output logic [VSWAP_CNT_BITS-1:0]    miss_cnt_o
);

    vswap_state_t state_q, state_d;

    logic [VICTIM_ADDR_BITS-1:0]  miss_addr_q, evict_addr_q;
    logic                         evict_valid_q, hit_q;
    logic [DCACHE_LINE_WIDTH-1:0] evict_data_q, vc_line_q, mem_line_q;
    logic                         accept, leave_lookup, mem_take;

    assign accept       = (state_q == StIdle) && miss_req_i && !flush_i;
    assign leave_lookup = (state_q == StLookup) && !flush_i;
    assign mem_take     = (state_q == StMemReq) && mem_ack_i && !flush_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (miss_req_i) state_d = StLookup;
            StLookup: state_d = StEvict;
            StEvict:  state_d = hit_q ? StFill : StMemReq;
            StMemReq: if (mem_ack_i) state_d = StFill;
            StFill:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (flush_i) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            miss_addr_q   <= '0;
            evict_valid_q <= 1'b0;
            evict_addr_q  <= '0;
            evict_data_q  <= '0;
            hit_q         <= 1'b0;
            vc_line_q     <= '0;
            mem_line_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                miss_addr_q   <= miss_addr_i;
                evict_valid_q <= evict_valid_i;
                evict_addr_q  <= evict_addr_i;
                evict_data_q  <= evict_data_i;
            end
            // Hit data is held here so a later evict write to the same entry cannot clobber it.
            if (leave_lookup) begin
                hit_q     <= vc_hit_i;
                vc_line_q <= vc_data_i;
            end
            if (mem_take) begin
                mem_line_q <= mem_data_i;
            end
        end
    end

    // A flush shares the victim cache's flush line, so side effects are squashed in that cycle.
    always_comb begin
        busy_o       = (state_q != StIdle);
        fill_valid_o = 1'b0;
        fill_addr_o  = '0;
        fill_data_o  = '0;
        vc_addr_o    = '0;
        vc_data_o    = '0;
        vc_write_o   = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        case (state_q)
            StLookup: vc_addr_o = miss_addr_q;
            StEvict: begin
                vc_addr_o  = evict_addr_q;
                vc_data_o  = evict_data_q;
                vc_write_o = evict_valid_q && !flush_i;
            end
            StMemReq: begin
                mem_req_o  = !flush_i;
                mem_addr_o = miss_addr_q;
            end
            StFill: begin
                fill_valid_o = !flush_i;
                fill_addr_o  = miss_addr_q;
                fill_data_o  = hit_q ? vc_line_q : mem_line_q;
            end
            default: ;
        endcase
    end

    sat_counter #(
        .Width(VSWAP_CNT_BITS)
    ) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (leave_lookup && vc_hit_i),
        .clr_i (1'b0),
        .cnt_o (hit_cnt_o)
    );

    sat_counter #(
        .Width(VSWAP_CNT_BITS)
    ) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (leave_lookup && !vc_hit_i),
        .clr_i (1'b0),
        .cnt_o (miss_cnt_o)
    );

endmodule
